// File: rtl/brnch_pred_pkg.sv
// Shared types and defaults for the branch-prediction PHT arbiter.
// Holds the 2-bit counter type, FSM states and the saturating-counter update.
package brnch_pred_pkg;

    localparam int IDX_W_DEF      = 5;
    localparam int PHT_DEPTH_DEF  = 32;
    localparam int UPDQ_DEPTH_DEF = 2;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_INIT = 2'b01;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_UPD_RD,
        ST_UPD_WR
    } state_t;

    function automatic ctr_t ctr_sat_upd(input ctr_t c, input logic taken);
        ctr_t r;
        if (taken) r = (c == 2'b11) ? c : c + 2'b01;
        else       r = (c == 2'b00) ? c : c - 2'b01;
        return r;
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Pending-update queue of resolved branches ({idx, taken}) awaiting a PHT read-modify-write.
// Simultaneous push and pop leave the occupancy unchanged.
module pht_upd_fifo
    import brnch_pred_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int DEPTH = UPDQ_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [IDX_W-1:0] i_push_idx,
    input  logic             i_push_taken,
    input  logic             i_pop,
    output logic [IDX_W-1:0] o_head_idx,
    output logic             o_head_taken,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [IDX_W-1:0] r_idx   [DEPTH];
    logic             r_taken [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full       = (r_count == CNT_FULL);
    assign o_empty      = (r_count == '0);
    assign w_push       = i_push & ~o_full;
    assign w_pop        = i_pop & ~o_empty;
    assign o_head_idx   = r_idx[r_rd_ptr];
    assign o_head_taken = r_taken[r_rd_ptr];

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_idx[r_wr_ptr]   <= i_push_idx;
            r_taken[r_wr_ptr] <= i_push_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/brnch_pht_arb_ctrl.sv
// Arbitrates a single-port external PHT between IF-stage lookups and queued ID-stage updates.
//   state     | meaning
//   ST_INIT   | sweep CTR_INIT into every PHT entry, ascending
//   ST_IDLE   | arbitrate: full queue > lookup > non-empty queue
//   ST_UPD_RD | issue cycle of an update read (IDLE cycle won by the queue)
//   ST_UPD_WR | write saturated counter back to the queue head, pop it
module brnch_pht_arb_ctrl
    import brnch_pred_pkg::*;
#(
    parameter int IDX_W      = IDX_W_DEF,
    parameter int PHT_DEPTH  = PHT_DEPTH_DEF,
    parameter int UPDQ_DEPTH = UPDQ_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_lkup_vld,
    input  logic [IDX_W-1:0] i_lkup_idx,
    output logic             o_lkup_rdy,
    output logic             o_pred_vld,
    output logic             o_pred_taken,
    input  logic             i_upd_vld,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken,
    output logic             o_upd_rdy,
    output logic             o_pht_en,
    output logic             o_pht_we,
    output logic [IDX_W-1:0] o_pht_addr,
    output logic [1:0]       o_pht_wdata,
    input  logic [1:0]       i_pht_rdata,
    output logic             o_init_done
);

    localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(PHT_DEPTH - 1);

    state_t           r_state;
    state_t           w_phase;
    logic [IDX_W-1:0] r_sweep;
    logic             r_sweep_en;
    logic             r_init_done;
    logic             r_pred_vld;
    logic             w_full;
    logic             w_empty;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_taken;
    logic             w_push;
    logic             w_pop;
    logic             w_upd_win;

    pht_upd_fifo #(
        .IDX_W (IDX_W),
        .DEPTH (UPDQ_DEPTH)
    ) u_upd_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_idx   (i_upd_idx),
        .i_push_taken (i_upd_taken),
        .i_pop        (w_pop),
        .o_head_idx   (w_head_idx),
        .o_head_taken (w_head_taken),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    assign w_upd_win    = w_full | (~i_lkup_vld & ~w_empty);
    assign o_lkup_rdy   = (r_state == ST_IDLE) & ~w_full;
    assign o_upd_rdy    = r_init_done & ~w_full;
    assign w_push       = i_upd_vld & o_upd_rdy;
    assign w_pop        = (r_state == ST_UPD_WR);
    assign o_pred_vld   = r_pred_vld;
    assign o_pred_taken = r_pred_vld & i_pht_rdata[1];
    assign o_init_done  = r_init_done;

    // An IDLE cycle won by the queue is the update-read cycle itself.
    always_comb begin
        w_phase = r_state;
        if ((r_state == ST_IDLE) && w_upd_win) w_phase = ST_UPD_RD;
    end

    always_comb begin
        o_pht_en    = 1'b0;
        o_pht_we    = 1'b0;
        o_pht_addr  = '0;
        o_pht_wdata = '0;
        case (w_phase)
            ST_INIT: begin
                o_pht_en    = r_sweep_en;
                o_pht_we    = r_sweep_en;
                o_pht_addr  = r_sweep;
                o_pht_wdata = CTR_INIT;
            end
            ST_IDLE: begin
                o_pht_en   = i_lkup_vld;
                o_pht_addr = i_lkup_idx;
            end
            ST_UPD_RD: begin
                o_pht_en   = 1'b1;
                o_pht_addr = w_head_idx;
            end
            ST_UPD_WR: begin
                o_pht_en    = 1'b1;
                o_pht_we    = 1'b1;
                o_pht_addr  = w_head_idx;
                o_pht_wdata = ctr_sat_upd(i_pht_rdata, w_head_taken);
            end
            default: ;
        endcase
    end

    // The sweep holds off one cycle after reset so the PHT port stays quiet while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_sweep     <= '0;
            r_sweep_en  <= 1'b0;
            r_init_done <= 1'b0;
            r_pred_vld  <= 1'b0;
        end else begin
            r_sweep_en <= 1'b1;
            r_pred_vld <= (w_phase == ST_IDLE) & i_lkup_vld;
            case (w_phase)
                ST_INIT: begin
                    if (r_sweep_en) begin
                        r_sweep <= r_sweep + IDX_W'(1);
                        if (r_sweep == SWEEP_LAST) begin
                            r_state     <= ST_IDLE;
                            r_init_done <= 1'b1;
                        end
                    end
                end
                ST_IDLE:   r_state <= ST_IDLE;
                ST_UPD_RD: r_state <= ST_UPD_WR;
                ST_UPD_WR: r_state <= ST_IDLE;
                default:   r_state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: doc/brnch_pht_arb_ctrl.md
BRNCH_PHT_ARB_CTRL -- requirements
Module: brnch_pht_arb_ctrl

Interface
REQ-001 Parameter IDX_W, 5, pattern-history-table (PHT) index width.
REQ-002 Parameter PHT_DEPTH, 32, PHT entries; must equal 2**IDX_W.
REQ-003 Parameter UPDQ_DEPTH, 2, depth of the pending-update queue.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 lkup_vld  in  1  IF-stage branch detected, prediction requested.
REQ-007 lkup_idx  in  IDX_W  PHT index (low branch-address bits).
REQ-008 lkup_rdy  out  1  lookup accepted this cycle when high with lkup_vld.
REQ-009 pred_vld  out  1  prediction valid (one cycle after acceptance).
REQ-010 pred_taken  out  1  predicted direction, meaningful only with pred_vld.
REQ-011 upd_vld  in  1  ID-stage branch resolved.
REQ-012 upd_idx  in  IDX_W  index of the resolved branch.
REQ-013 upd_taken  in  1  actual branch outcome.
REQ-014 upd_rdy  out  1  update queue can accept.
REQ-015 pht_en, pht_we  out  1 each  single-port PHT enable / write enable.
REQ-016 pht_addr  out  IDX_W; pht_wdata  out  2; pht_rdata  in  2 (valid one cycle after a read).
REQ-017 init_done  out  1  PHT initialisation sweep complete.

Function
REQ-018 FSM states INIT, IDLE, UPD_RD, UPD_WR; one PHT access per cycle maximum.
REQ-019 INIT: write CTR_INIT (2'b01) to addresses 0..PHT_DEPTH-1, one per cycle, ascending; after address PHT_DEPTH-1 go to IDLE, init_done=1 from the next cycle onward.
REQ-020 In INIT, lkup_rdy=0 and upd_rdy=0.
REQ-021 IDLE/UPD_RD priority: queue full -> start update read; else lkup_vld -> lookup read; else queue non-empty -> update read.
REQ-022 lkup_rdy=1 in IDLE or UPD_RD-issue cycles only when the lookup wins per REQ-021; lkup_rdy=0 in UPD_WR.
REQ-023 Accepted lookup at cycle T: pht_en=1, pht_we=0, pht_addr=lkup_idx in T; pred_vld=1 and pred_taken=pht_rdata[1] in T+1.
REQ-024 Update read at T (state UPD_RD): pht_addr=queue head idx; at T+1 (UPD_WR) pht_we=1, same address, pht_wdata=saturating update of pht_rdata; queue pops at T+1.
REQ-025 Saturation: taken -> +1 capped at 2'b11; not-taken -> -1 floored at 2'b00.
REQ-026 UPD_WR always completes; next state IDLE, re-arbitrated per REQ-021 same cycle.
REQ-027 upd_rdy = init_done & (count < UPDQ_DEPTH); push and pop in the same cycle allowed, count unchanged.
REQ-028 No lookup/update bypass: a lookup to an index with a queued update returns the pre-update counter.
REQ-029 No PHT access when idle with no requests (pht_en=0).

Reset
REQ-030 rst_n low: state=INIT, sweep address=0, queue empty, pred_vld=0, pred_taken=0, lkup_rdy=0, upd_rdy=0, init_done=0, pht_en=0, pht_we=0.
REQ-031 Reset mid-operation discards queued updates and an in-flight UPD_WR; sweep restarts from address 0.

Structure
REQ-032 Package brnch_pred_pkg holds ctr_t (2-bit counter typedef), state enum, CTR_INIT, default IDX_W/PHT_DEPTH/UPDQ_DEPTH.
REQ-033 Queue implemented in sub-module pht_upd_fifo (entries {idx, taken}, count, full/empty).
REQ-034 PHT storage is external; this block contains no counter array.

Verification
REQ-035 Release reset -> 32 writes of 2'b01 at addrs 0..31, init_done=1 at cycle 33, no lkup_rdy before.
REQ-036 After init, lookup idx 5 -> pht read addr 5, next cycle pred_vld=1, pred_taken=0.
REQ-037 Three updates idx 5 taken, then lookup idx 5 -> counter 01->10->11->11, pred_taken=1.
REQ-038 Two updates queued (full) with lkup_vld held -> update RD/WR wins, lkup_rdy=0 for 2 cycles, then lookup accepted.
REQ-039 Update idx 0 not-taken twice from 2'b01 -> writes 2'b00 then 2'b00 (floor).
REQ-040 Assert rst_n low during UPD_WR with one queued entry -> queue empty, INIT sweep restarts at addr 0.
